cnn_top: RTL and testbench

//  Top level of the binary-image CNN classifier.
//  - Collects one 28x28 1-bit image (784 px) as 98 bytes, stores it in a 784x1 input RAM.
//  - Starts the existing CNN core (cnn_core) and captures its predicted class.
//  - Sends the class back as one 8N1 UART byte on TX.
//  - Sits between the board UART and cnn_core.

---
 rtl/cnn_top.sv | 262 ++++++++++++++++++++++++++
 tb/tb_cnn_top.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_top.sv
// ---------------------------------------------------------------------------
// cnn_top: top level of the binary-image CNN classifier.
//
// Collects one 28x28 1-bit image (98 bytes, LSB of each byte = lowest pixel
// index) into a bit-wide input RAM, starts the classifier core, captures the
// predicted class and returns it as a single 8N1 UART byte on TX.
//
// Ports (top):
//   clk      in   1  system clock, all logic on the rising edge
//   RST_n    in   1  asynchronous active-low reset
//   RX       in   1  serial receive pin, reserved (ignored)
//   TX       out  1  UART transmit, 8N1, idle high
//   rx_data  in   8  received image byte, valid with rx_rdy
//   rx_rdy   in   1  byte strobe, one byte accepted per high clock in LOAD
//
// Sub-modules in this file:
//   cnn_input_ram  784x1 pixel store, byte-wide write, 1-clock registered read
//   cnn_core       reference classifier: scans all pixels, pred = ones mod 10
// ---------------------------------------------------------------------------

// Pixel RAM: one write port that stores a whole byte as 8 consecutive pixels,
// one read port with a single clock of latency. Contents are never reset.
module cnn_input_ram #(
    parameter int NUM_PIX = 784
) (
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [6:0] i_wrByte,
    input  logic [7:0] i_wrData,
    input  logic [9:0] i_rdAddr,
    output logic       o_rdBit
);
    logic       ram [0:NUM_PIX-1];
    logic       r_rdBit;
    logic [9:0] w_base;

    assign w_base  = {i_wrByte, 3'b000};
    assign o_rdBit = r_rdBit;

    // Byte write fans out to 8 pixels; read data is registered.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int k = 0; k < 8; k++) begin
                ram[w_base + 10'(k)] <= i_wrData[k];
            end
        end
        r_rdBit <= ram[i_rdAddr];
    end
endmodule

// Reference classifier core. On a start pulse it walks img_addr over every
// pixel, counts set pixels modulo 10 and pulses done for one clock with pred
// valid alongside it. The read data arrives one clock after the address, so
// r_pend/r_last track which cycles carry a valid pixel.
module cnn_core #(
    parameter int NUM_PIX = 784
) (
    input  logic       i_clk,
    input  logic       i_rstN,
    input  logic       i_start,
    input  logic       i_imgBit,
    output logic [9:0] o_imgAddr,
    output logic       o_done,
    output logic [3:0] o_pred
);
    localparam logic [9:0] LAST_ADDR = 10'(NUM_PIX - 1);

    logic       r_run;
    logic       r_pend;
    logic       r_last;
    logic       r_done;
    logic [9:0] r_addr;
    logic [3:0] r_cnt;

    assign o_imgAddr = r_addr;
    assign o_done    = r_done;
    assign o_pred    = r_cnt;

    // Address sweep plus a mod-10 ones counter fed by the delayed pixel.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_run  <= 1'b0;
            r_pend <= 1'b0;
            r_last <= 1'b0;
            r_done <= 1'b0;
            r_addr <= '0;
            r_cnt  <= '0;
        end else begin
            r_pend <= r_run;
            r_last <= r_run && (r_addr == LAST_ADDR);
            r_done <= r_last;
            if (i_start && !r_run && !r_pend) begin
                r_run  <= 1'b1;
                r_addr <= '0;
                r_cnt  <= '0;
            end else begin
                if (r_run) begin
                    if (r_addr == LAST_ADDR) begin
                        r_run  <= 1'b0;
                        r_addr <= '0;
                    end else begin
                        r_addr <= r_addr + 10'd1;
                    end
                end
                if (r_pend && i_imgBit) begin
                    r_cnt <= (r_cnt == 4'd9) ? 4'd0 : r_cnt + 4'd1;
                end
            end
        end
    end
endmodule

module cnn_top #(
    parameter int BAUD_DIV  = 434,
    parameter int NUM_BYTES = 98
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       RX,
    output logic       TX,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy
);
    localparam int          BW        = $clog2(BAUD_DIV);
    localparam logic [6:0]  LAST_BYTE = 7'(NUM_BYTES - 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {LOAD, START, RUN, SEND, TXW} state_t;

    state_t          state;
    state_t          w_nextState;
    logic [6:0]      byte_cnt;
    logic            trmt;
    logic [7:0]      tx_data;
    logic            w_coreStart;
    logic            w_ramWe;
    logic            w_imgBit;
    logic            w_coreDone;
    logic [9:0]      w_imgAddr;
    logic [3:0]      w_pred;
    logic [9:0]      r_shift;
    logic [BW-1:0]   r_baudCnt;
    logic [3:0]      r_bitCnt;
    logic            r_txBusy;
    logic            w_txDone;
    logic            w_unusedRx;

    assign w_unusedRx = RX;

    cnn_input_ram #(.NUM_PIX(NUM_BYTES * 8)) input_ram (
        .i_clk    (clk),
        .i_we     (w_ramWe),
        .i_wrByte (byte_cnt),
        .i_wrData (rx_data),
        .i_rdAddr (w_imgAddr),
        .o_rdBit  (w_imgBit)
    );

    cnn_core #(.NUM_PIX(NUM_BYTES * 8)) core (
        .i_clk     (clk),
        .i_rstN    (RST_n),
        .i_start   (w_coreStart),
        .i_imgBit  (w_imgBit),
        .o_imgAddr (w_imgAddr),
        .o_done    (w_coreDone),
        .o_pred    (w_pred)
    );

    // State register.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state <= LOAD;
        end else begin
            state <= w_nextState;
        end
    end

    // Next state and single-cycle strobes; rx_rdy only writes in LOAD.
    always_comb begin
        w_nextState = state;
        trmt        = 1'b0;
        w_coreStart = 1'b0;
        w_ramWe     = 1'b0;
        case (state)
            LOAD: begin
                w_ramWe = rx_rdy;
                if (rx_rdy && (byte_cnt == LAST_BYTE)) begin
                    w_nextState = START;
                end
            end
            START: begin
                w_coreStart = 1'b1;
                w_nextState = RUN;
            end
            RUN: begin
                if (w_coreDone) begin
                    w_nextState = SEND;
                end
            end
            SEND: begin
                trmt        = 1'b1;
                w_nextState = TXW;
            end
            TXW: begin
                if (w_txDone) begin
                    w_nextState = LOAD;
                end
            end
            default: w_nextState = LOAD;
        endcase
    end

    // Byte counter wraps to 0 after the last byte of an image.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            byte_cnt <= '0;
        end else if (w_ramWe) begin
            byte_cnt <= (byte_cnt == LAST_BYTE) ? 7'd0 : byte_cnt + 7'd1;
        end
    end

    // Result byte is captured only on done and held until the next one.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            tx_data <= '0;
        end else if ((state == RUN) && w_coreDone) begin
            tx_data <= {4'b0000, w_pred};
        end
    end

    // UART shifter: the frame {stop, data, start} shifts out LSB first with
    // ones filled in behind, so TX sits at 1 whenever the shifter is idle.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_shift   <= '1;
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_txBusy  <= 1'b0;
        end else if (trmt) begin
            r_shift   <= {1'b1, tx_data, 1'b0};
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_txBusy  <= 1'b1;
        end else if (r_txBusy) begin
            if (r_baudCnt == BAUD_LAST) begin
                r_baudCnt <= '0;
                r_shift   <= {1'b1, r_shift[9:1]};
                if (r_bitCnt == 4'd9) begin
                    r_txBusy <= 1'b0;
                    r_bitCnt <= '0;
                end else begin
                    r_bitCnt <= r_bitCnt + 4'd1;
                end
            end else begin
                r_baudCnt <= r_baudCnt + 1'b1;
            end
        end
    end

    assign w_txDone = r_txBusy && (r_baudCnt == BAUD_LAST) && (r_bitCnt == 4'd9);
    assign TX       = r_shift[0];
endmodule

// File: tb/tb_cnn_top.sv
// ---------------------------------------------------------------------------
// tb_cnn_top: directed bench for cnn_top. Images are described by a small
// record (fill pattern, fill length, last byte) and the expected class is the
// reference core's result, ones-count mod 10, worked out by hand per record.
// ---------------------------------------------------------------------------
module tb_cnn_top;
   localparam int BAUD_DIV  = 434;
   localparam int NUM_BYTES = 98;
   localparam int NUM_PIX   = NUM_BYTES * 8;

   logic       clk = 1'b0;
   logic       RST_n;
   logic       RX;
   logic       TX;
   logic [7:0] rx_data;
   logic       rx_rdy;

   int         total = 0;
   int         bad = 0;
   int         trmtCount = 0;
   int         startCount = 0;
   logic [7:0] txLog [$];

   typedef struct {
      string      name;
      logic [7:0] pat;
      int         count;
      logic [7:0] last;
      logic [7:0] expTx;
      int         gap;
      bit         noise;
   } vec_t;

   always #5 clk = ~clk;

   cnn_top #(.BAUD_DIV(BAUD_DIV), .NUM_BYTES(NUM_BYTES)) dut (
      .clk     (clk),
      .RST_n   (RST_n),
      .RX      (RX),
      .TX      (TX),
      .rx_data (rx_data),
      .rx_rdy  (rx_rdy)
   );

   // Counts strobes and logs each transmitted byte, sampled mid-cycle.
   always @(negedge clk) begin
      if (dut.trmt === 1'b1) begin
         trmtCount++;
         txLog.push_back(dut.tx_data);
      end
      if (dut.w_coreStart === 1'b1) begin
         startCount++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] imgByte(input vec_t v, input int i);
      if (i == NUM_BYTES - 1) return v.last;
      if (i < v.count) return v.pat;
      return 8'h00;
   endfunction

   // Sends image bytes [first, last) with the record's idle gap after each.
   task automatic applyStimulus(input vec_t v, input int first, input int last);
      for (int i = first; i < last; i++) begin
         rx_data = imgByte(v, i);
         rx_rdy  = 1'b1;
         tick();
         rx_rdy  = 1'b0;
         rx_data = 8'h00;
         repeat (v.gap) tick();
      end
   endtask

   // Waits for the result, checks the strobe, the UART frame bit by bit over
   // every clock of each bit, the return to LOAD and the stored image.
   task automatic checkOutput(input vec_t v, input int startsBefore, input int trmtBefore);
      int         n;
      int         wrong;
      logic [9:0] frame;
      logic       seen;
      logic [7:0] b;
      if (v.noise) begin
         repeat (5) tick();
         repeat (3) begin
            rx_data = 8'hFF;
            rx_rdy  = 1'b1;
            tick();
            rx_rdy  = 1'b0;
            tick();
         end
      end
      n = 0;
      while (dut.trmt !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      check({v.name, " trmt seen"}, 32'(dut.trmt), 32'd1);
      check({v.name, " tx_data"}, 32'(dut.tx_data), 32'(v.expTx));
      frame = {1'b1, v.expTx, 1'b0};
      for (int bi = 0; bi < 10; bi++) begin
         seen = frame[bi];
         for (int s = 0; s < BAUD_DIV; s++) begin
            tick();
            if (v.noise && s == 200 && (bi == 2 || bi == 7)) begin
               rx_data = 8'hFF;
               rx_rdy  = 1'b1;
            end else begin
               rx_rdy  = 1'b0;
            end
            if (TX !== frame[bi]) seen = TX;
         end
         check($sformatf("%s TX bit %0d", v.name, bi), 32'(seen), 32'(frame[bi]));
      end
      rx_rdy = 1'b0;
      tick();
      check({v.name, " TX idle"}, 32'(TX), 32'd1);
      check({v.name, " byte_cnt"}, 32'(dut.byte_cnt), 32'd0);
      check({v.name, " start pulses"}, 32'(startCount - startsBefore), 32'd1);
      check({v.name, " trmt pulses"}, 32'(trmtCount - trmtBefore), 32'd1);
      wrong = 0;
      for (int i = 0; i < NUM_PIX; i++) begin
         b = imgByte(v, i / 8);
         if (dut.input_ram.ram[i] !== b[i % 8]) wrong++;
      end
      check({v.name, " ram mismatching pixels"}, 32'(wrong), 32'd0);
   endtask

   initial begin
      vec_t vecs [4];
      vec_t vR;
      vec_t v3;
      vec_t v7;
      int   sb;
      int   tb;

      // 5 ones -> 5; 20x A5 (80) + bit 783 -> 81 -> 1; all ones 784 -> 4; none -> 0
      vecs[0] = '{"five", 8'h01, 5, 8'h00, 8'h05, 10, 1'b1};
      vecs[1] = '{"a5mix", 8'hA5, 20, 8'h80, 8'h01, 0, 1'b0};
      vecs[2] = '{"allones", 8'hFF, 98, 8'hFF, 8'h04, 0, 1'b0};
      vecs[3] = '{"zeros", 8'h00, 0, 8'h00, 8'h00, 0, 1'b0};
      vR      = '{"afterrst", 8'h3C, 11, 8'h00, 8'h04, 0, 1'b0};
      v3      = '{"three", 8'h07, 1, 8'h00, 8'h03, 0, 1'b0};
      v7      = '{"seven", 8'h7F, 1, 8'h00, 8'h07, 0, 1'b0};

      RST_n   = 1'b0;
      RX      = 1'b1;
      rx_rdy  = 1'b0;
      rx_data = 8'h00;
      repeat (3) tick();
      check("reset TX", 32'(TX), 32'd1);
      check("reset trmt", 32'(dut.trmt), 32'd0);
      check("reset tx_data", 32'(dut.tx_data), 32'd0);
      check("reset byte_cnt", 32'(dut.byte_cnt), 32'd0);
      RST_n = 1'b1;
      tick();

      for (int k = 0; k < 4; k++) begin
         sb = startCount;
         tb = trmtCount;
         applyStimulus(vecs[k], 0, NUM_BYTES);
         checkOutput(vecs[k], sb, tb);
      end

      // Reset part-way through an image, then a full image.
      applyStimulus(vR, 0, 40);
      check("mid byte_cnt before reset", 32'(dut.byte_cnt), 32'd40);
      RST_n = 1'b0;
      tick();
      check("mid reset TX", 32'(TX), 32'd1);
      check("mid reset tx_data", 32'(dut.tx_data), 32'd0);
      check("mid reset byte_cnt", 32'(dut.byte_cnt), 32'd0);
      RST_n = 1'b1;
      tick();
      sb = startCount;
      tb = trmtCount;
      applyStimulus(vR, 0, NUM_BYTES - 1);
      repeat (3) tick();
      check("no start before last byte", 32'(startCount - sb), 32'd0);
      applyStimulus(vR, NUM_BYTES - 1, NUM_BYTES);
      checkOutput(vR, sb, tb);

      // Back-to-back images must come out in order.
      sb = startCount;
      tb = trmtCount;
      applyStimulus(v3, 0, NUM_BYTES);
      checkOutput(v3, sb, tb);
      sb = startCount;
      tb = trmtCount;
      applyStimulus(v7, 0, NUM_BYTES);
      checkOutput(v7, sb, tb);
      check("log length", 32'(txLog.size()), 32'd7);
      if (txLog.size() >= 2) begin
         check("first of pair", 32'(txLog[txLog.size() - 2]), 32'h03);
         check("second of pair", 32'(txLog[txLog.size() - 1]), 32'h07);
      end else begin
         check("pair present", 32'(txLog.size()), 32'd2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
